// File: rtl/matrix_operand_stager.sv
// Serial-to-parallel operand stager: collects PORT_COUNT multiplier elements, then
// PORT_COUNT multiplicand elements, pulses mStart, and captures and holds the accelerator result.
module matrix_operand_stager #(
  parameter int BIT_LENGTH = 16,
  parameter int PORT_COUNT = 4
) (
  input  logic                             Clk,
  input  logic                             Rst,
  input  logic                             abort,
  input  logic [BIT_LENGTH-1:0]            in_data,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic [PORT_COUNT*BIT_LENGTH-1:0] multiplier_out,
  output logic [PORT_COUNT*BIT_LENGTH-1:0] multiplicand_out,
  output logic                             mStart,
  input  logic                             acc_ready,
  input  logic [BIT_LENGTH-1:0]            acc_sum,
  output logic [BIT_LENGTH-1:0]            sum,
  output logic                             sum_valid,
  input  logic                             sum_ready,
  output logic                             busy
);
  localparam int CW = (PORT_COUNT > 1) ? $clog2(PORT_COUNT) : 1;
  localparam logic [CW-1:0] LAST = CW'(PORT_COUNT - 1);

  typedef enum logic [2:0] {LOAD_A, LOAD_B, START, WAIT_ACC, HOLD} state_t;

  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic [BIT_LENGTH-1:0] r_mul [PORT_COUNT];
  logic [BIT_LENGTH-1:0] r_mcd [PORT_COUNT];
  logic [BIT_LENGTH-1:0] r_sum;
  logic                  r_sum_valid;
  logic                  r_mstart;

  logic                  w_load;
  logic                  w_xfer;
  logic                  w_last;
  logic [PORT_COUNT-1:0] w_sel;

  // abort gates in_ready so an element presented alongside it is never handshaken
  assign w_load   = (r_state == LOAD_A) || (r_state == LOAD_B);
  assign in_ready = w_load && !Rst && !abort;
  assign w_xfer   = in_valid && in_ready;
  assign w_last   = (r_cnt == LAST);

  genvar k;
  generate
    for (k = 0; k < PORT_COUNT; k++) begin : g_lane
      assign w_sel[k] = w_xfer && (r_cnt == CW'(k));

      always_ff @(posedge Clk) begin
        if (Rst) begin
          r_mul[k] <= '0;
          r_mcd[k] <= '0;
        end else begin
          if (w_sel[k] && (r_state == LOAD_A)) r_mul[k] <= in_data;
          if (w_sel[k] && (r_state == LOAD_B)) r_mcd[k] <= in_data;
        end
      end

      assign multiplier_out[k*BIT_LENGTH +: BIT_LENGTH]   = r_mul[k];
      assign multiplicand_out[k*BIT_LENGTH +: BIT_LENGTH] = r_mcd[k];
    end
  endgenerate

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state     <= LOAD_A;
      r_cnt       <= '0;
      r_sum       <= '0;
      r_sum_valid <= 1'b0;
      r_mstart    <= 1'b0;
    end else if (abort) begin
      r_state     <= LOAD_A;
      r_cnt       <= '0;
      r_sum_valid <= 1'b0;
      r_mstart    <= 1'b0;
    end else begin
      r_mstart <= 1'b0;
      unique case (r_state)
        LOAD_A: if (w_xfer) begin
          if (w_last) begin
            r_cnt   <= '0;
            r_state <= LOAD_B;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        LOAD_B: if (w_xfer) begin
          if (w_last) begin
            r_cnt    <= '0;
            r_mstart <= 1'b1;
            r_state  <= START;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        // acc_ready is deliberately not looked at here
        START: r_state <= WAIT_ACC;
        WAIT_ACC: if (acc_ready) begin
          r_sum       <= acc_sum;
          r_sum_valid <= 1'b1;
          r_state     <= HOLD;
        end
        HOLD: if (r_sum_valid && sum_ready) begin
          r_sum_valid <= 1'b0;
          r_state     <= LOAD_A;
        end
        default: r_state <= LOAD_A;
      endcase
    end
  end

  assign mStart    = r_mstart;
  assign sum       = r_sum;
  assign sum_valid = r_sum_valid;
  assign busy      = (r_state != LOAD_A) || (r_cnt != '0);
endmodule

// File: tb/tb_matrix_operand_stager.sv
// Randomized bench for matrix_operand_stager; expected operand vectors come from an
// element-index model of which lane each accepted element lands in.
module tb_matrix_operand_stager;
  localparam int W = 16;
  localparam int P = 4;

  logic           Clk = 1'b0;
  logic           Rst = 1'b1;
  logic           abort = 1'b0;
  logic [W-1:0]   in_data = '0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [P*W-1:0] multiplier_out, multiplicand_out;
  logic           mStart;
  logic           acc_ready = 1'b0;
  logic [W-1:0]   acc_sum = '0;
  logic [W-1:0]   sum;
  logic           sum_valid;
  logic           sum_ready = 1'b0;
  logic           busy;

  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0] mA [P];
  logic [W-1:0] mB [P];
  int           mk = 0;
  logic [W-1:0] stim [$];

  always #5 Clk = ~Clk;

  matrix_operand_stager #(.BIT_LENGTH(W), .PORT_COUNT(P)) dut (
    .Clk(Clk), .Rst(Rst), .abort(abort), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .multiplier_out(multiplier_out), .multiplicand_out(multiplicand_out),
    .mStart(mStart), .acc_ready(acc_ready), .acc_sum(acc_sum), .sum(sum),
    .sum_valid(sum_valid), .sum_ready(sum_ready), .busy(busy)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic next();
    @(posedge Clk);
    #1;
  endtask

  task automatic settle();
    @(negedge Clk);
  endtask

  function automatic logic [P*W-1:0] packA();
    logic [P*W-1:0] v = '0;
    for (int k = 0; k < P; k++) v[k*W +: W] = mA[k];
    return v;
  endfunction

  function automatic logic [P*W-1:0] packB();
    logic [P*W-1:0] v = '0;
    for (int k = 0; k < P; k++) v[k*W +: W] = mB[k];
    return v;
  endfunction

  task automatic model_put(input logic [W-1:0] d);
    if (mk < P) mA[mk] = d;
    else        mB[mk-P] = d;
    mk = (mk + 1) % (2*P);
  endtask

  task automatic model_clear();
    for (int k = 0; k < P; k++) begin
      mA[k] = '0;
      mB[k] = '0;
    end
    mk = 0;
  endtask

  task automatic fill_random(input int n);
    stim.delete();
    for (int i = 0; i < n; i++) stim.push_back(W'($urandom));
  endtask

  // Entered and left at posedge+1; on return after a full operation the DUT is in START.
  task automatic load_op(input int n, input bit toggle, output int cyc);
    int  done = 0;
    bit  xfer;
    cyc = 0;
    while (done < n && cyc < 20*n) begin
      in_valid = toggle ? (cyc % 2 == 0) : 1'b1;
      in_data  = stim[0];
      settle();
      xfer = in_valid && in_ready;
      next();
      if (xfer) begin
        model_put(stim.pop_front());
        done++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    if (done < n) begin
      n_vec++; n_err++;
      $display("FAIL load_timeout: got %0d transfers, need %0d", done, n);
    end
  endtask

  // Entered in the START cycle at posedge+1; junk input is offered throughout to prove back-pressure.
  task automatic run_acc(input int dly, input logic [W-1:0] s, input int hold);
    int pulses = 0;
    int rdy = 0;
    in_valid = 1'b1;
    in_data  = W'($urandom);
    settle();
    n_vec++;
    if (mStart !== 1'b1) begin n_err++; $display("FAIL mstart_pulse: got %b need 1", mStart); end
    if (in_ready) rdy++;
    for (int i = 0; i < dly; i++) begin
      next();
      settle();
      if (mStart) pulses++;
      if (in_ready) rdy++;
    end
    acc_ready = 1'b1;
    acc_sum   = s;
    next();
    acc_ready = 1'b0;
    acc_sum   = W'($urandom);
    for (int i = 0; i < hold; i++) begin
      settle();
      n_vec++;
      if (sum_valid !== 1'b1 || sum !== s) begin
        n_err++;
        $display("FAIL hold_stable[%0d]: got valid=%b sum=%h need valid=1 sum=%h", i, sum_valid, sum, s);
      end
      if (mStart) pulses++;
      if (in_ready) rdy++;
      next();
    end
    sum_ready = 1'b1;
    settle();
    n_vec++;
    if (sum_valid !== 1'b1) begin n_err++; $display("FAIL valid_before_consume: got %b need 1", sum_valid); end
    next();
    sum_ready = 1'b0;
    in_valid  = 1'b0;
    settle();
    n_vec++;
    if (sum_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || sum !== s) begin
      n_err++;
      $display("FAIL consume: got valid=%b busy=%b rdy=%b sum=%h need 0 0 1 %h", sum_valid, busy, in_ready, sum, s);
    end
    n_vec++;
    if (pulses != 0 || rdy != 0) begin
      n_err++;
      $display("FAIL extra_activity: got %0d extra mStart, %0d in_ready, need 0 0", pulses, rdy);
    end
    n_vec++;
    if (multiplier_out !== packA() || multiplicand_out !== packB()) begin
      n_err++;
      $display("FAIL vec_hold: got A=%h B=%h need A=%h B=%h", multiplier_out, multiplicand_out, packA(), packB());
    end
    next();
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    model_clear();
    repeat (2) next();
    settle();
    n_vec++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b need 0", in_ready); end
    n_vec++;
    if (multiplier_out !== '0 || multiplicand_out !== '0 || sum !== '0 || sum_valid !== 1'b0 ||
        mStart !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got A=%h B=%h sum=%h sv=%b ms=%b busy=%b need all 0",
               multiplier_out, multiplicand_out, sum, sum_valid, mStart, busy);
    end
    Rst = 1'b0;
    next();
    settle();
    n_vec++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset: got rdy=%b busy=%b need 1 0", in_ready, busy);
    end
    next();
  endtask

  task automatic test_fixed_stream();
    int cyc;
    logic [P*W-1:0] expa, expb;
    expa = 64'h0004_0003_0002_0001;
    expb = 64'h0008_0007_0006_0005;
    stim.delete();
    for (int i = 1; i <= 2*P; i++) stim.push_back(W'(i));
    load_op(2*P, 1'b0, cyc);
    n_vec++;
    if (multiplier_out !== expa || multiplicand_out !== expb) begin
      n_err++;
      $display("FAIL fixed_vectors: got A=%h B=%h need A=%h B=%h", multiplier_out, multiplicand_out, expa, expb);
    end
    n_vec++;
    if (cyc != 2*P) begin n_err++; $display("FAIL fixed_cycles: got %0d need %0d", cyc, 2*P); end
    run_acc(3, 16'h0046, 5);
  endtask

  task automatic test_toggle_valid();
    int cyc;
    fill_random(2*P);
    load_op(2*P, 1'b1, cyc);
    n_vec++;
    if (cyc != 15) begin n_err++; $display("FAIL toggle_cycles: got %0d need 15", cyc); end
    n_vec++;
    if (multiplier_out !== packA() || multiplicand_out !== packB()) begin
      n_err++;
      $display("FAIL toggle_vectors: got A=%h B=%h need A=%h B=%h", multiplier_out, multiplicand_out, packA(), packB());
    end
    run_acc($urandom_range(4, 1), W'($urandom), $urandom_range(3, 0));
  endtask

  task automatic test_abort();
    int cyc;
    fill_random(P + 3);
    load_op(P + 3, 1'b0, cyc);
    in_valid = 1'b1;
    in_data  = W'($urandom);
    abort    = 1'b1;
    settle();
    n_vec++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL abort_in_ready: got %b need 0", in_ready); end
    next();
    abort    = 1'b0;
    in_valid = 1'b0;
    mk       = 0;
    settle();
    n_vec++;
    if (mStart !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL abort_state: got ms=%b busy=%b need 0 0", mStart, busy);
    end
    n_vec++;
    if (multiplier_out !== packA() || multiplicand_out !== packB()) begin
      n_err++;
      $display("FAIL abort_retain: got A=%h B=%h need A=%h B=%h", multiplier_out, multiplicand_out, packA(), packB());
    end
    next();
    fill_random(2*P);
    load_op(2*P, 1'b0, cyc);
    n_vec++;
    if (multiplier_out !== packA() || multiplicand_out !== packB()) begin
      n_err++;
      $display("FAIL abort_reload: got A=%h B=%h need A=%h B=%h", multiplier_out, multiplicand_out, packA(), packB());
    end
    run_acc($urandom_range(3, 1), W'($urandom), 1);
  endtask

  task automatic test_reset_in_wait();
    int cyc;
    fill_random(2*P);
    load_op(2*P, 1'b0, cyc);
    next();
    Rst       = 1'b1;
    acc_ready = 1'b1;
    acc_sum   = W'($urandom);
    next();
    settle();
    n_vec++;
    if (sum !== '0 || sum_valid !== 1'b0 || mStart !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 ||
        multiplier_out !== '0 || multiplicand_out !== '0) begin
      n_err++;
      $display("FAIL reset_in_wait: got sum=%h sv=%b ms=%b busy=%b rdy=%b A=%h B=%h need all 0",
               sum, sum_valid, mStart, busy, in_ready, multiplier_out, multiplicand_out);
    end
    Rst       = 1'b0;
    acc_ready = 1'b0;
    model_clear();
    next();
    settle();
    n_vec++;
    if (in_ready !== 1'b1 || sum_valid !== 1'b0) begin
      n_err++;
      $display("FAIL after_reset_in_wait: got rdy=%b sv=%b need 1 0", in_ready, sum_valid);
    end
    next();
  endtask

  task automatic test_acc_held();
    int cyc;
    int sv = 0;
    int ms = 0;
    logic [W-1:0] s;
    s = W'($urandom);
    fill_random(2*P);
    load_op(2*P, 1'b0, cyc);
    acc_ready = 1'b1;
    acc_sum   = s;
    sum_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      settle();
      if (sum_valid) sv++;
      if (mStart) ms++;
      next();
      if (i == 2) acc_ready = 1'b0;
    end
    sum_ready = 1'b0;
    n_vec++;
    if (sv != 1 || ms != 1) begin
      n_err++;
      $display("FAIL acc_held_counts: got %0d valid cycles %0d pulses need 1 1", sv, ms);
    end
    n_vec++;
    if (sum !== s || busy !== 1'b0) begin
      n_err++;
      $display("FAIL acc_held_sum: got sum=%h busy=%b need %h 0", sum, busy, s);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    for (int r = 0; r < 4; r++) begin
      fill_random(2*P);
      load_op(2*P, 1'b0, cyc);
      n_vec++;
      if (cyc != 2*P) begin n_err++; $display("FAIL b2b_cycles[%0d]: got %0d need %0d", r, cyc, 2*P); end
      run_acc($urandom_range(5, 1), W'($urandom), $urandom_range(4, 0));
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_fixed_stream();
    test_toggle_valid();
    test_abort();
    test_reset_in_wait();
    test_acc_held();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
